i2c_reg_bank: RTL
=================

Name: i2c_reg_bank

Overview:
Register bank that sits directly downstream of the EFB I2C slave engine and consumes the bytes it produces. Write bursts are staged and committed atomically at end of transaction. The bank also answers single-byte reads from the engine for master reads, and drives an interrupt line to the host.
Memory map, with N = MEMORY_MAP_SIZE:
- RW registers: 0x00..N-11
- Read-only status: N-10..N-3
- INT_FLAG: N-2
- INT_EN: N-1

Parameters:
MEMORY_MAP_SIZE, 8'd50, total mapped bytes; must be >= 11.
MAX_MEM_BURST_NUM, 8, staging-buffer depth (bytes per write burst).
INTQ_OPENDRAIN, "ON", "ON": intq_n drives 0 or Z; otherwise drives 0 or 1.

Ports:
clk  in  1  system clock (12.09 MHz OSCH).
RST_N  in  1  asynchronous active-low reset.
bus_start  in  1  pulse; opens a write burst at bus_addr.
bus_addr  in  8  burst start address (sampled with bus_start) / read address (sampled with bus_rd).
bus_wr  in  1  pulse; stage bus_wdata at the current burst address, then auto-increment.
bus_wdata  in  8  write data.
bus_stop  in  1  pulse; end of burst, commit staged bytes.
bus_abort  in  1  pulse; discard staged bytes.
bus_rd  in  1  pulse; read request.
rd_data  out  8  read data.
rd_valid  out  1  one-cycle pulse, rd_data valid.
busy  out  1  high while collecting or committing.
sts_i  in  64  status bytes; byte k maps to address N-10+k.
ext_evt_i  in  4  external event inputs, rising-edge detected.
led_o  out  8  register 0x00.
ctrl_o  out  8  register 0x01.
intq_n  out  1  active-low interrupt.

Behaviour:
- Reset (async, RST_N low):
  - all RW regs, INT_FLAG and INT_EN = 0x00; staging cleared; state IDLE.
  - rd_data = 0x00; rd_valid = 0; busy = 0; led_o/ctrl_o = 0x00.
  - intq_n inactive (Z if INTQ_OPENDRAIN = "ON", else 1).
- Reset mid-commit leaves no partial result: every register returns to its reset value.
- FSM states: IDLE, COLLECT, COMMIT.
- IDLE:
  - bus_start -> COLLECT; wr_ptr = bus_addr; count = 0.
  - bus_wr, bus_stop, bus_abort are ignored.
- COLLECT:
  - bus_wr with count < MAX_MEM_BURST_NUM: store {wr_ptr, bus_wdata}; wr_ptr++ (8-bit wrap 0xFF->0x00); count++.
  - bus_wr with count == MAX_MEM_BURST_NUM: byte dropped; INT_FLAG[1] (overflow) set.
  - bus_start: restart; staging discarded; new base address.
  - bus_abort: -> IDLE; staging discarded; no flags.
  - bus_stop with count = 0: -> IDLE; no flag.
  - bus_stop with count > 0: -> COMMIT.
- COMMIT:
  - Commits one entry per clock in arrival order, so a later write to the same address wins.
  - Target is an RW address: register = data.
  - Target is INT_EN: INT_EN = data.
  - Target is INT_FLAG: write-1-to-clear (INT_FLAG &= ~data).
  - Target is RO or >= N: entry discarded; INT_FLAG[2] set.
  - After the last entry -> IDLE; INT_FLAG[0] (commit done) set in that same cycle.
  - Latency from bus_stop to the last register update = count clocks; busy drops the cycle after.
  - bus_start/bus_wr arriving in COMMIT are ignored and set INT_FLAG[1].
- busy = (state != IDLE).
- Reads:
  - Accepted in any state, always from committed contents; staged data is never visible.
  - Latency: rd_data/rd_valid registered, valid exactly 1 cycle after bus_rd.
  - Unmapped address returns 0x00.
  - Reading INT_FLAG has no side effect.
  - bus_rd on consecutive cycles gives consecutive rd_valid pulses.
  - rd_data holds its value when rd_valid = 0.
- INT_FLAG[7:4]:
  - Set on the rising edge of ext_evt_i[3:0], through a 2-flop synchronizer plus an edge register.
  - Edge-to-flag latency is 3 clocks.
- Set/clear priority: in the same cycle, a hardware set wins over a W1C clear.
- intq_n asserted (0) while (INT_FLAG & INT_EN) != 0; registered, 1-cycle delay from the flag/enable change.

Decomposition:
- Shared package/define file, alongside the existing EFB defines:
  - FSM state encodings.
  - INT_FLAG bit indices: DONE = 0, OVF = 1, ADRERR = 2, EVT = 7:4.
  - Address offsets derived from MEMORY_MAP_SIZE: RW_END, STS_BASE, INT_FLAG_ADR, INT_EN_ADR.
- One sub-module, i2c_burst_stage: MAX_MEM_BURST_NUM x 16-bit staging buffer, write pointer, count, and a sequential read-out port for COMMIT.

Test Plan:
1. Burst write: bus_start addr 0x00, bus_wr 0xA5, 0x3C, bus_stop -> led_o = 0xA5 and ctrl_o = 0x3C exactly 2 clocks after bus_stop; INT_FLAG = 0x01; intq_n stays inactive (INT_EN = 0).
2. Overflow: 9 bus_wr at addr 0x02 with MAX = 8 -> regs 0x02..0x09 written; 9th byte dropped; INT_FLAG[1] = 1; a write of 0x02 to INT_EN then drives intq_n = 0; W1C 0x02 to INT_FLAG releases intq_n.
3. Abort/atomicity: bus_start 0x05, bus_wr 0x77, bus_rd 0x05 during COLLECT -> rd_data 0x00; bus_abort -> reg 0x05 remains 0x00; no flags set.
4. Read-only/range check: burst at 0x28 (N = 50) writing 0x11 -> discarded; INT_FLAG[2] = 1; bus_rd 0x28 with sts_i[7:0] = 0x5A -> rd_data 0x5A one clock later; bus_rd 0x40 -> 0x00.
5. Event vs clear: ext_evt_i[0] rising edge in the same cycle as the committed W1C 0x10 -> INT_FLAG[4] remains 1; INT_EN = 0x10 -> intq_n = 0.
6. Reset mid-COMMIT: assert RST_N low while count = 4 -> all outputs return to reset values immediately; no partial writes persist after release.

Source files
------------

// File: rtl/i2c_reg_bank_pkg.sv
// Shared types and constants for the I2C register bank: FSM states, INT_FLAG bit
// positions, staging entry layout and memory-map offsets derived from the map size.
package i2c_reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    localparam int unsigned FLG_DONE    = 0;
    localparam int unsigned FLG_OVF     = 1;
    localparam int unsigned FLG_ADRERR  = 2;
    localparam int unsigned FLG_EVT_LSB = 4;

    localparam int unsigned STS_BYTES = 8;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } stage_entry_t;

    function automatic int unsigned rw_end(input int unsigned n);
        return n - 11;
    endfunction

    function automatic int unsigned sts_base(input int unsigned n);
        return n - 10;
    endfunction

    function automatic int unsigned int_flag_adr(input int unsigned n);
        return n - 2;
    endfunction

    function automatic int unsigned int_en_adr(input int unsigned n);
        return n - 1;
    endfunction

endpackage

// File: rtl/i2c_reg_bank_if.sv
// Byte-level handshake between the I2C slave engine (master side) and the register bank.
interface i2c_reg_bank_if;
    logic       bus_start;
    logic [7:0] bus_addr;
    logic       bus_wr;
    logic [7:0] bus_wdata;
    logic       bus_stop;
    logic       bus_abort;
    logic       bus_rd;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;

    modport master (
        output bus_start, bus_addr, bus_wr, bus_wdata, bus_stop, bus_abort, bus_rd,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  bus_start, bus_addr, bus_wr, bus_wdata, bus_stop, bus_abort, bus_rd,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/i2c_burst_stage.sv
// Write-burst staging buffer: collects {addr, data} entries with an auto-incrementing
// address and replays them in arrival order for the commit phase.
module i2c_burst_stage
    import i2c_reg_bank_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [7:0]       addr_i,
    input  logic             push_i,
    input  logic [7:0]       data_i,
    input  logic             pop_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_c,
    output stage_entry_t     head_c,
    output logic             last_c
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    stage_entry_t     mem_q [DEPTH];
    stage_entry_t     mem_d [DEPTH];
    logic [7:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] rd_q, rd_d;

    assign count_o = cnt_q;
    assign full_c  = (cnt_q == CNT_W'(DEPTH));
    assign head_c  = mem_q[rd_q];
    assign last_c  = ((CNT_W'(rd_q) + CNT_W'(1)) == cnt_q);

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        rd_d  = rd_q;
        if (clr_i) begin
            cnt_d = '0;
            rd_d  = '0;
        end else if (start_i) begin
            ptr_d = addr_i;
            cnt_d = '0;
            rd_d  = '0;
        end else begin
            if (push_i && !full_c) begin
                mem_d[IDX_W'(cnt_q)] = '{addr: ptr_q, data: data_i};
                ptr_d = ptr_q + 8'd1;
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (pop_i) begin
                rd_d = rd_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            ptr_q <= '0;
            cnt_q <= '0;
            rd_q  <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind the EFB I2C slave: atomic burst writes, single-byte reads,
// W1C interrupt flags with enable mask and an active-low interrupt request.
module i2c_reg_bank
    import i2c_reg_bank_pkg::*;
#(
    parameter int unsigned MEMORY_MAP_SIZE   = 50,
    parameter int unsigned MAX_MEM_BURST_NUM = 8,
    parameter string       INTQ_OPENDRAIN    = "ON"
) (
    input  logic                 clk,
    input  logic                 RST_N,
    i2c_reg_bank_if.slave        bus,
    input  logic [63:0]          sts_i,
    input  logic [3:0]           ext_evt_i,
    output logic [7:0]           led_o,
    output logic [7:0]           ctrl_o,
    output logic                 intq_n
);

    localparam int unsigned RW_NUM   = rw_end(MEMORY_MAP_SIZE) + 1;
    localparam int unsigned RW_IDX_W = (RW_NUM > 1) ? $clog2(RW_NUM) : 1;
    localparam int unsigned STS_LO   = sts_base(MEMORY_MAP_SIZE);
    localparam int unsigned STS_HI   = STS_LO + STS_BYTES - 1;
    localparam int unsigned FLAG_ADR = int_flag_adr(MEMORY_MAP_SIZE);
    localparam int unsigned EN_ADR   = int_en_adr(MEMORY_MAP_SIZE);
    localparam int unsigned STG_CNT_W = $clog2(MAX_MEM_BURST_NUM + 1);

    state_e         state_q, state_d;
    logic [7:0]     rw_q [RW_NUM];
    logic [7:0]     rw_d [RW_NUM];
    logic [7:0]     int_flag_q, int_flag_d;
    logic [7:0]     int_en_q, int_en_d;
    logic [3:0]     evt_s1_q, evt_s1_d, evt_s2_q, evt_s2_d, evt_s3_q, evt_s3_d;
    logic           irq_q, irq_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;

    logic [7:0]     flag_set, flag_clr;
    logic [31:0]    hd_adr, rd_adr;
    logic [2:0]     sts_idx;

    logic                 stg_start, stg_push, stg_pop, stg_clr;
    logic [STG_CNT_W-1:0] stg_count;
    logic                 stg_full, stg_last;
    stage_entry_t         stg_head;

    i2c_burst_stage #(.DEPTH(MAX_MEM_BURST_NUM)) u_stage (
        .clk     (clk),
        .rst_n   (RST_N),
        .start_i (stg_start),
        .addr_i  (bus.bus_addr),
        .push_i  (stg_push),
        .data_i  (bus.bus_wdata),
        .pop_i   (stg_pop),
        .clr_i   (stg_clr),
        .count_o (stg_count),
        .full_c  (stg_full),
        .head_c  (stg_head),
        .last_c  (stg_last)
    );

    // Burst FSM, commit decode and flag update
    always_comb begin
        state_d   = state_q;
        stg_start = 1'b0;
        stg_push  = 1'b0;
        stg_pop   = 1'b0;
        stg_clr   = 1'b0;
        flag_set  = '0;
        flag_clr  = '0;
        rw_d      = rw_q;
        int_en_d  = int_en_q;
        hd_adr    = 32'(stg_head.addr);
        case (state_q)
            ST_IDLE: begin
                if (bus.bus_start) begin
                    stg_start = 1'b1;
                    state_d   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus.bus_start) begin
                    stg_start = 1'b1;
                end else if (bus.bus_abort) begin
                    stg_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.bus_stop) begin
                    state_d = (stg_count == '0) ? ST_IDLE : ST_COMMIT;
                end else if (bus.bus_wr) begin
                    if (stg_full) flag_set[FLG_OVF] = 1'b1;
                    else          stg_push          = 1'b1;
                end
            end
            ST_COMMIT: begin
                stg_pop = 1'b1;
                if (hd_adr < RW_NUM)          rw_d[RW_IDX_W'(stg_head.addr)] = stg_head.data;
                else if (hd_adr == EN_ADR)    int_en_d = stg_head.data;
                else if (hd_adr == FLAG_ADR)  flag_clr = stg_head.data;
                else                          flag_set[FLG_ADRERR] = 1'b1;
                if (stg_last) begin
                    stg_clr = 1'b1;
                    state_d = ST_IDLE;
                    flag_set[FLG_DONE] = 1'b1;
                end
                if (bus.bus_start || bus.bus_wr) flag_set[FLG_OVF] = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        evt_s1_d = ext_evt_i;
        evt_s2_d = evt_s1_q;
        evt_s3_d = evt_s2_q;
        flag_set[FLG_EVT_LSB +: 4] = evt_s2_q & ~evt_s3_q;
        // A hardware set in the same cycle overrides a W1C clear
        int_flag_d = (int_flag_q & ~flag_clr) | flag_set;
        irq_d      = |(int_flag_q & int_en_q);
    end

    // Read port always returns committed contents
    always_comb begin
        rd_valid_d = bus.bus_rd;
        rd_data_d  = rd_data_q;
        rd_adr     = 32'(bus.bus_addr);
        sts_idx    = 3'(rd_adr - STS_LO);
        if (bus.bus_rd) begin
            if (rd_adr < RW_NUM)                         rd_data_d = rw_q[RW_IDX_W'(bus.bus_addr)];
            else if (rd_adr >= STS_LO && rd_adr <= STS_HI) rd_data_d = sts_i[{sts_idx, 3'b000} +: 8];
            else if (rd_adr == FLAG_ADR)                 rd_data_d = int_flag_q;
            else if (rd_adr == EN_ADR)                   rd_data_d = int_en_q;
            else                                         rd_data_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            rw_q       <= '{default: '0};
            int_flag_q <= '0;
            int_en_q   <= '0;
            evt_s1_q   <= '0;
            evt_s2_q   <= '0;
            evt_s3_q   <= '0;
            irq_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            int_flag_q <= int_flag_d;
            int_en_q   <= int_en_d;
            evt_s1_q   <= evt_s1_d;
            evt_s2_q   <= evt_s2_d;
            evt_s3_q   <= evt_s3_d;
            irq_q      <= irq_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign led_o        = rw_q[0];

    if (RW_NUM > 1) begin : g_ctrl
        assign ctrl_o = rw_q[1];
    end else begin : g_no_ctrl
        assign ctrl_o = 8'h00;
    end

    if (INTQ_OPENDRAIN == "ON") begin : g_intq_od
        assign intq_n = irq_q ? 1'b0 : 1'bz;
    end else begin : g_intq_pp
        assign intq_n = ~irq_q;
    end

endmodule
